// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer with pipeline stall
// One shared 64-bit accumulator: shift-add (LSB first) for multiply, restoring divide (MSB first).
module muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              cancel,
  output logic              busy,
  output logic              stall,
  output logic              res_valid,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIXUP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                negq_q, negq_d, negr_q, negr_d, div0_q, div0_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic                is_div, is_signed, last_iter;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W:0]     mul_sum, div_shift;
  logic [DATA_W-1:0]   div_sub;
  logic                div_ge;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));
  assign abs_a     = (is_signed && a_q[DATA_W-1]) ? -a_q : a_q;
  assign abs_b     = (is_signed && b_q[DATA_W-1]) ? -b_q : b_q;

  assign mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Partial remainder is always below the divisor, so the low W bits of the difference are exact when ge.
  assign div_shift = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_sub   = div_shift[DATA_W-1:0] - opnd_q;

  assign prod_fix  = negq_q ? -acc_q : acc_q;
  assign quo_fix   = negq_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix   = negr_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_PREP;
        S_PREP:  state_d = S_RUN;
        S_RUN:   if (last_iter) state_d = S_FIXUP;
        S_FIXUP: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIXUP);
    stall     = busy || ((state_q == S_IDLE) && start && !cancel);
    res_valid = (state_q == S_DONE);
  end

  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    negq_d = negq_q;
    negr_d = negr_q;
    div0_d = div0_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (state_q)
      S_IDLE: if (start && !cancel) begin
        op_d = op;
        a_d  = src_a;
        b_d  = src_b;
      end
      S_PREP: begin
        opnd_d = is_div ? abs_b : abs_a;
        acc_d  = {{DATA_W{1'b0}}, (is_div ? abs_a : abs_b)};
        negq_d = is_signed && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
        negr_d = is_signed && a_q[DATA_W-1];
        div0_d = is_div && (b_q == '0);
        cnt_d  = '0;
      end
      S_RUN: begin
        if (is_div) acc_d = {(div_ge ? div_sub : div_shift[DATA_W-1:0]), acc_q[DATA_W-2:0], div_ge};
        else        acc_d = {mul_sum, acc_q[DATA_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIXUP: if (!cancel) begin
        if (!is_div) begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      opnd_q <= opnd_d;
      acc_q  <= acc_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      div0_q <= div0_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  logic        clk, resetn, start, cancel;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall, res_valid;
  logic [31:0] hi, lo;
  int          checks, passed;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  muldiv_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .busy(busy), .stall(stall), .res_valid(res_valid), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues an op in the current cycle (T0) and follows it to DONE; noise keeps start high
  // and scrambles op/operands while the engine is busy.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic noise, input logic [31:0] ehi, input logic [31:0] elo);
    int   n;
    logic bad;
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1;
    check({tag, " stall@T0"}, 64'(stall), 64'd1);
    check({tag, " busy@T0"}, 64'(busy), 64'd0);
    bad = 1'b0;
    tick();
    n = 1;
    if (!noise) start = 1'b0;
    while (!res_valid && n < 60) begin
      if (!(stall && busy)) bad = 1'b1;
      if (noise) begin
        src_a = $urandom;
        src_b = $urandom;
        op    = 2'($urandom);
      end
      tick();
      n++;
    end
    check({tag, " stall window"}, 64'(bad), 64'd0);
    check({tag, " latency"}, 64'(n), 64'd35);
    check({tag, " stall@done"}, 64'(stall), 64'd0);
    check({tag, " busy@done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    checks = 0; passed = 0;
    resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst stall", 64'(stall), 64'd0);
    check("rst valid", 64'(res_valid), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    do_op("multu max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    check("after done valid", 64'(res_valid), 64'd0);

    do_op("mult -3*5", MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    tick();
    do_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick();
    do_op("divu by 0", DIVU, 32'h0000_1234, 32'd0, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF);
    tick();
    do_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
    tick();

    // cancel at T10 of DIVU 100/7
    op = DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    check("cancel stall", 64'(stall), 64'd0);
    check("cancel valid", 64'(res_valid), 64'd0);
    check("cancel hi kept", 64'(hi), 64'h0);
    check("cancel lo kept", 64'(lo), 64'h8000_0000);
    tick();
    do_op("divu 100/7", DIVU, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
    tick();

    do_op("start in run", DIVU, 32'd1000, 32'd3, 1'b1, 32'd1, 32'd333);
    start = 1'b0;
    tick();

    op = MULTU; src_a = 32'd9; src_b = 32'd9; start = 1'b1; cancel = 1'b1;
    #1;
    check("start+cancel stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0; cancel = 1'b0;
    check("start+cancel busy", 64'(busy), 64'd0);
    tick();
    check("start+cancel busy2", 64'(busy), 64'd0);
    check("start+cancel hi kept", 64'(hi), 64'd1);

    // asynchronous reset at T20 of a MULTU
    op = MULTU; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #2 resetn = 1'b0;
    #1;
    check("async rst hi", 64'(hi), 64'd0);
    check("async rst lo", 64'(lo), 64'd0);
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst valid", 64'(res_valid), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    do_op("multu 6*7", MULTU, 32'd6, 32'd7, 1'b0, 32'd0, 32'd42);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
